// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue/wait/respond sequencer for the alu_8bit
// load/done interface, with a wait timeout for a hung ALU.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [1:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [1:0]  rsp_op,
  output logic        rsp_timeout,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [1:0]  alu_op_sel,
  output logic        alu_load,
  input  logic [15:0] alu_result,
  input  logic        alu_done,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [CW-1:0] wcnt;
  logic          push;
  logic          pop;
  logic [17:0]   head;

  assign cmd_ready = (count != FULL);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) & (count != '0);
  assign busy      = (state != IDLE) | (count != '0);
  assign head      = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Only one op in flight: the head is popped solely from IDLE,
  // which is re-entered only after the response handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wcnt        <= '0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_op_sel  <= '0;
      alu_load    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_op      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            alu_op_sel <= head[17:16];
            alu_A      <= head[15:8];
            alu_B      <= head[7:0];
            rsp_op     <= head[17:16];
            alu_load   <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          alu_load <= 1'b0;
          wcnt     <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (alu_done) begin
            rsp_result  <= alu_result;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (wcnt == TLAST) begin
            rsp_result  <= 16'hFFFF;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
